// File: rtl/edge_frame_sequencer_if.sv
// -----------------------------------------------------------------------------
// edge_frame_sequencer_if
// Bundles every non-clock, non-reset signal of the Prewitt frame sequencer:
// frame control, frame-memory read port, filter input/output ports and the
// coordinate-tagged output pixel stream.
//
// Modports:
//   master : the sequencer (drives busy/done, memory reads, filter input,
//            output stream; receives control, read data and filter output)
//   slave  : the environment (frame memory, filter, controller, sink)
// -----------------------------------------------------------------------------
interface edge_frame_sequencer_if #(
  parameter int ROWS = 242,
  parameter int COLS = 247
);
  localparam int AW = $clog2(ROWS * COLS);
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);

  // frame control
  logic          start;
  logic          abort;
  logic          hold;
  logic          busy;
  logic          done;
  // frame memory read port
  logic          mem_rd;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_rdata;
  // filter ports
  logic          filt_valid_in;
  logic [7:0]    filt_pixel_in;
  logic          filt_valid_out;
  logic [7:0]    filt_pixel_out;
  // output pixel stream
  logic          out_valid;
  logic [7:0]    out_pixel;
  logic [RW-1:0] out_row;
  logic [CW-1:0] out_col;

  modport master (
    input  start, abort, hold, mem_rdata, filt_valid_out, filt_pixel_out,
    output busy, done, mem_rd, mem_addr, filt_valid_in, filt_pixel_in,
           out_valid, out_pixel, out_row, out_col
  );

  modport slave (
    output start, abort, hold, mem_rdata, filt_valid_out, filt_pixel_out,
    input  busy, done, mem_rd, mem_addr, filt_valid_in, filt_pixel_in,
           out_valid, out_pixel, out_row, out_col
  );
endinterface

// File: rtl/edge_frame_sequencer.sv
// -----------------------------------------------------------------------------
// edge_frame_sequencer
// Frame-level controller for the 3x3 Prewitt filter. Reads one ROWS x COLS
// frame from a synchronous memory (1-cycle read latency), streams it into the
// filter, pushes ALIGN zero pixels to flush the filter pipeline, then realigns
// the filter output into exactly ROWS*COLS row/column-tagged pixels with the
// border forced to zero.
//
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous, active-high reset
//   bus  : edge_frame_sequencer_if.master (control, memory, filter, output)
// -----------------------------------------------------------------------------
module edge_frame_sequencer #(
  parameter int ROWS  = 242,
  parameter int COLS  = 247,
  parameter int ALIGN = COLS + 3,
  parameter int AW    = $clog2(ROWS * COLS)
) (
  input logic                    clk,
  input logic                    rst,
  edge_frame_sequencer_if.master bus
);

  localparam int N  = ROWS * COLS;
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam int OW = $clog2(N + ALIGN + 1);  // filter output counter
  localparam int EW = $clog2(N + 1);          // emitted pixel counter
  localparam int FW = $clog2(ALIGN + 1);      // flush pulse counter

  localparam logic [AW-1:0] LAST_ADDR  = AW'(N - 1);
  localparam logic [FW-1:0] LAST_FLUSH = FW'(ALIGN - 1);
  localparam logic [OW-1:0] ALIGN_O    = OW'(ALIGN);
  localparam logic [EW-1:0] N_EMIT     = EW'(N);
  localparam logic [RW-1:0] LAST_ROW   = RW'(ROWS - 1);
  localparam logic [CW-1:0] LAST_COL   = CW'(COLS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_FLUSH,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic          w_busy;
  logic          w_done;
  logic          w_rd_issue;
  logic          w_flush_issue;
  logic          w_border;

  logic [AW-1:0] r_addr;
  logic [FW-1:0] r_flush_cnt;
  logic [OW-1:0] r_o_cnt;
  logic [EW-1:0] r_emit_cnt;
  logic [RW-1:0] r_row;
  logic [CW-1:0] r_col;
  logic          r_fv_in;
  logic          r_from_mem;
  logic          r_out_valid;
  logic [7:0]    r_out_pixel;
  logic [RW-1:0] r_out_row;
  logic [CW-1:0] r_out_col;

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // ---------------------------------------------------------------------------
  // Next-state and strobes. Abort suppresses new reads/flush pulses in the
  // cycle it is seen, so nothing new enters the pipe while leaving the frame.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a value
    // unassigned, which would otherwise infer a latch.
    w_next        = r_state;
    w_busy        = 1'b0;
    w_done        = 1'b0;
    w_rd_issue    = 1'b0;
    w_flush_issue = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (bus.start && !bus.abort) w_next = S_FETCH;
      end
      S_FETCH: begin
        w_busy = 1'b1;
        if (bus.abort) begin
          w_next = S_IDLE;
        end else if (!bus.hold) begin
          w_rd_issue = 1'b1;
          if (r_addr == LAST_ADDR) w_next = S_FLUSH;
        end
      end
      S_FLUSH: begin
        w_busy = 1'b1;
        if (bus.abort) begin
          w_next = S_IDLE;
        end else if (!bus.hold) begin
          w_flush_issue = 1'b1;
          if (r_flush_cnt == LAST_FLUSH) w_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        w_busy = 1'b1;
        if (bus.abort)                 w_next = S_IDLE;
        else if (r_emit_cnt == N_EMIT) w_next = S_DONE;
      end
      S_DONE: begin
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Border test uses the coordinates of the pixel about to be emitted.
  assign w_border = (r_row == '0) || (r_row == LAST_ROW) ||
                    (r_col == '0) || (r_col == LAST_COL);

  // ---------------------------------------------------------------------------
  // Counters, filter input pipe and output realignment
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr      <= '0;
      r_flush_cnt <= '0;
      r_o_cnt     <= '0;
      r_emit_cnt  <= '0;
      r_row       <= '0;
      r_col       <= '0;
      r_fv_in     <= 1'b0;
      r_from_mem  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_pixel <= '0;
      r_out_row   <= '0;
      r_out_col   <= '0;
    end else begin
      // Read data returns one cycle after mem_rd, exactly when this strobe is
      // presented to the filter; flush pulses carry pixel 0.
      r_fv_in     <= w_rd_issue | w_flush_issue;
      r_from_mem  <= w_rd_issue;
      r_out_valid <= 1'b0;

      if (r_state == S_IDLE || bus.abort) begin
        r_addr      <= '0;
        r_flush_cnt <= '0;
        r_o_cnt     <= '0;
        r_emit_cnt  <= '0;
        r_row       <= '0;
        r_col       <= '0;
      end else begin
        // Wrap to 0 after the last read so the address never exceeds AW bits.
        if (w_rd_issue)    r_addr      <= (r_addr == LAST_ADDR) ? '0 : r_addr + 1'b1;
        if (w_flush_issue) r_flush_cnt <= r_flush_cnt + 1'b1;
        // Completion counts pixels actually presented on the output port.
        if (r_out_valid)   r_emit_cnt  <= r_emit_cnt + 1'b1;

        if (w_busy && bus.filt_valid_out) begin
          r_o_cnt <= r_o_cnt + 1'b1;
          // The first ALIGN filter outputs precede raster pixel 0; drop them.
          if (r_o_cnt >= ALIGN_O) begin
            r_out_valid <= 1'b1;
            r_out_row   <= r_row;
            r_out_col   <= r_col;
            r_out_pixel <= w_border ? 8'd0 : bus.filt_pixel_out;
            if (r_col == LAST_COL) begin
              r_col <= '0;
              r_row <= r_row + 1'b1;
            end else begin
              r_col <= r_col + 1'b1;
            end
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Port drive
  // ---------------------------------------------------------------------------
  assign bus.busy          = w_busy;
  assign bus.done          = w_done;
  assign bus.mem_rd        = w_rd_issue;
  assign bus.mem_addr      = r_addr;
  assign bus.filt_valid_in = r_fv_in;
  assign bus.filt_pixel_in = r_from_mem ? bus.mem_rdata : 8'd0;
  assign bus.out_valid     = r_out_valid;
  assign bus.out_pixel     = r_out_pixel;
  assign bus.out_row       = r_out_row;
  assign bus.out_col       = r_out_col;

endmodule
